// File: rtl/invader_formation_if.sv
// Formation controller bus: game/bullet inputs and renderer/FSM outputs.
interface invader_formation_if #(
    parameter int ROWS = 5,
    parameter int COLS = 4,
    parameter int XW   = 10,
    parameter int YW   = 10
);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic                 start;
    logic [2:0]           level;
    logic                 bull_valid;
    logic [XW-1:0]        bull_x;
    logic [YW-1:0]        bull_y;
    logic                 hit;
    logic [CW-1:0]        hit_col;
    logic [RW-1:0]        hit_row;
    logic [ROWS*COLS-1:0] alive;
    logic [XW-1:0]        form_x;
    logic [YW-1:0]        form_y;
    logic                 dir_left;
    logic                 cleared;
    logic                 landed;

    modport master (
        output start, level, bull_valid, bull_x, bull_y,
        input  hit, hit_col, hit_row, alive, form_x, form_y,
        input  dir_left, cleared, landed
    );

    modport slave (
        input  start, level, bull_valid, bull_x, bull_y,
        output hit, hit_col, hit_row, alive, form_x, form_y,
        output dir_left, cleared, landed
    );
endinterface

// File: rtl/invader_formation.sv
// ROWS x COLS invader grid: march, edge drop, attrition speed-up,
// bullet hit resolution and cleared/landed reporting.
module invader_formation #(
    parameter int ROWS        = 5,
    parameter int COLS        = 4,
    parameter int CELL_SH     = 4,
    parameter int XW          = 10,
    parameter int YW          = 10,
    parameter int X_START     = 32,
    parameter int Y_START     = 32,
    parameter int X_MAX       = 608,
    parameter int STEP_X      = 4,
    parameter int Y_LAND      = 448,
    parameter int BASE_PERIOD = 2400000
) (
    input logic             dclk,
    input logic             clr,
    invader_formation_if.slave bus
);
    localparam int N  = ROWS * COLS;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int TW = $clog2(BASE_PERIOD + 1);

    localparam logic [XW-1:0] XS     = XW'(X_START);
    localparam logic [XW-1:0] XM     = XW'(X_MAX);
    localparam logic [XW-1:0] STEP   = XW'(STEP_X);
    localparam logic [XW-1:0] FORM_W = XW'(COLS << CELL_SH);
    localparam logic [YW-1:0] YS     = YW'(Y_START);
    localparam logic [YW-1:0] YL     = YW'(Y_LAND);
    localparam logic [YW-1:0] FORM_H = YW'(ROWS << CELL_SH);
    localparam logic [YW-1:0] CELL_H = YW'(1 << CELL_SH);

    typedef enum logic [2:0] {
        IDLE, MARCH, DROP, CLEARED, LANDED
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  alive_q, alive_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          left_q, left_d;
    logic          hit_q, hit_d;
    logic [CW-1:0] hcol_q, hcol_d;
    logic [RW-1:0] hrow_q, hrow_d;
    logic          cleared_q, cleared_d;
    logic          landed_q, landed_d;
    logic [TW-1:0] timer_q, timer_d;

    logic [TW-1:0] period;
    logic          step_due;
    logic [XW-1:0] col_w;
    logic [YW-1:0] row_w;
    logic          in_grid;
    logic [N-1:0]  cell_sel;
    logic          hit_now;
    logic [YW-1:0] y_drop;

    always_comb begin
        period = TW'(BASE_PERIOD) >> bus.level;
        if ($countones(alive_q) <= COLS) period = period >> 1;
        step_due = ({1'b0, timer_q} + 1'b1) >= {1'b0, period};

        // Out-of-range cells fall off the grid instead of wrapping.
        col_w   = (bus.bull_x - x_q) >> CELL_SH;
        row_w   = (bus.bull_y - y_q) >> CELL_SH;
        in_grid = (bus.bull_x >= x_q) && (bus.bull_y >= y_q) &&
                  (col_w < XW'(COLS)) && (row_w < YW'(ROWS));
        cell_sel = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                cell_sel[r*COLS+c] = in_grid &&
                                     (row_w == YW'(r)) &&
                                     (col_w == XW'(c));
            end
        end
        hit_now = bus.bull_valid && |(cell_sel & alive_q) &&
                  ((state_q == MARCH) || (state_q == DROP));
        y_drop = y_q + CELL_H;

        state_d   = state_q;
        alive_d   = alive_q;
        x_d       = x_q;
        y_d       = y_q;
        left_d    = left_q;
        hit_d     = 1'b0;
        hcol_d    = hcol_q;
        hrow_d    = hrow_q;
        cleared_d = cleared_q;
        landed_d  = landed_q;
        timer_d   = timer_q;

        if (bus.start) begin
            state_d   = MARCH;
            alive_d   = '1;
            x_d       = XS;
            y_d       = YS;
            left_d    = 1'b0;
            timer_d   = '0;
            cleared_d = 1'b0;
            landed_d  = 1'b0;
        end else begin
            if (hit_now) begin
                alive_d = alive_q & ~cell_sel;
                hit_d   = 1'b1;
                hcol_d  = CW'(col_w);
                hrow_d  = RW'(row_w);
            end
            unique case (state_q)
                MARCH: begin
                    if (alive_q == '0) begin
                        state_d   = CLEARED;
                        cleared_d = 1'b1;
                    end else if (step_due) begin
                        timer_d = '0;
                        if (!left_q) begin
                            if (x_q + STEP + FORM_W > XM) state_d = DROP;
                            else x_d = x_q + STEP;
                        end else begin
                            if (x_q < STEP) state_d = DROP;
                            else x_d = x_q - STEP;
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                DROP: begin
                    y_d    = y_drop;
                    left_d = !left_q;
                    if (y_drop + FORM_H >= YL) begin
                        state_d  = LANDED;
                        landed_d = 1'b1;
                    end else begin
                        state_d = MARCH;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge dclk or negedge clr) begin
        if (!clr) begin
            state_q   <= IDLE;
            alive_q   <= '0;
            x_q       <= XS;
            y_q       <= YS;
            left_q    <= 1'b0;
            hit_q     <= 1'b0;
            hcol_q    <= '0;
            hrow_q    <= '0;
            cleared_q <= 1'b0;
            landed_q  <= 1'b0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            alive_q   <= alive_d;
            x_q       <= x_d;
            y_q       <= y_d;
            left_q    <= left_d;
            hit_q     <= hit_d;
            hcol_q    <= hcol_d;
            hrow_q    <= hrow_d;
            cleared_q <= cleared_d;
            landed_q  <= landed_d;
            timer_q   <= timer_d;
        end
    end

    assign bus.hit      = hit_q;
    assign bus.hit_col  = hcol_q;
    assign bus.hit_row  = hrow_q;
    assign bus.alive    = alive_q;
    assign bus.form_x   = x_q;
    assign bus.form_y   = y_q;
    assign bus.dir_left = left_q;
    assign bus.cleared  = cleared_q;
    assign bus.landed   = landed_q;
endmodule
